// File: rtl/ip_codma_read_machine_if.sv
// System-bus read port of the CODMA read machine.
// master: the read machine (requests, address, size); slave: arbiter/memory side.
interface ip_codma_read_machine_if #(
    parameter int DATA_W = 64
);
    logic              bus_req;
    logic              bus_read;
    logic [31:0]       bus_addr;
    logic [3:0]        bus_size;
    logic              bus_grant;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_error;

    modport master (
        output bus_req, bus_read, bus_addr, bus_size,
        input  bus_grant, bus_valid, bus_data, bus_error
    );

    modport slave (
        input  bus_req, bus_read, bus_addr, bus_size,
        output bus_grant, bus_valid, bus_data, bus_error
    );
endinterface

// File: rtl/ip_codma_read_machine.sv
// CODMA read machine: arbitrates for the system bus, issues one 1/2/4-beat
// burst read and unpacks each 64-bit beat into an 8 x 32-bit word buffer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RD_IDLE    | waiting for need_read_i; illegal size gives an error pulse
// RD_ASK     | bus_req asserted, waiting for bus_grant
// RD_GRANTED | read strobe asserted, collecting beats until burst total
// RD_UNUSED  | illegal encoding; flags rd_state_error_o, returns to idle
module ip_codma_read_machine #(
    parameter int BUF_WORDS = 8,
    parameter int DATA_W    = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      need_read_i,
    input  logic [31:0]               addr_i,
    input  logic [3:0]                size_i,
    input  logic                      stop_i,
    ip_codma_read_machine_if.master   bus,
    output logic [32*BUF_WORDS-1:0]   rd_buf_o,
    output logic [7:0]                word_count_rd_o,
    output logic                      rd_done_o,
    output logic                      rd_error_o,
    output logic                      rd_state_error_o,
    output logic                      rd_busy_o
);

    localparam int IDX_W = $clog2(BUF_WORDS);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ASK     = 2'd1,
        RD_GRANTED = 2'd2,
        RD_UNUSED  = 2'd3
    } state_t;

    // Plain vector so an illegal encoding can be represented and recovered from.
    logic [1:0]        state_q;
    logic [31:0]       word_buf_q [BUF_WORDS];
    logic [DATA_W-1:0] beat;
    logic [IDX_W-1:0]  wr_idx_lo;
    logic [IDX_W-1:0]  wr_idx_hi;

    function automatic logic size_legal(input logic [3:0] s);
        return (s == 4'd3) || (s == 4'd8) || (s == 4'd9);
    endfunction

    function automatic logic [7:0] burst_words(input logic [3:0] s);
        case (s)
            4'd3:    return 8'd2;
            4'd8:    return 8'd4;
            4'd9:    return 8'd8;
            default: return 8'd0;
        endcase
    endfunction

    assign beat = bus.bus_data;

    // Count is always even, so the upper word lands at count with bit 0 set.
    assign wr_idx_lo = word_count_rd_o[IDX_W-1:0];
    assign wr_idx_hi = {wr_idx_lo[IDX_W-1:1], 1'b1};

    // Flatten the word buffer onto the output bus, word n at bits [32n+31:32n].
    for (genvar g = 0; g < BUF_WORDS; g++) begin : g_flat
        assign rd_buf_o[32*g +: 32] = word_buf_q[g];
    end

    // Read-machine FSM with registered bus handshake and status outputs.
    always_ff @(posedge clk_i) begin
        rd_done_o  <= 1'b0;
        rd_error_o <= 1'b0;
        if (reset_i) begin
            state_q          <= RD_IDLE;
            bus.bus_req      <= 1'b0;
            bus.bus_read     <= 1'b0;
            bus.bus_addr     <= '0;
            bus.bus_size     <= '0;
            word_count_rd_o  <= '0;
            rd_state_error_o <= 1'b0;
            rd_busy_o        <= 1'b0;
            for (int i = 0; i < BUF_WORDS; i++) begin
                word_buf_q[i] <= '0;
            end
        end else if (bus.bus_error && (state_q != RD_IDLE)) begin
            // Any beat presented alongside the error is dropped.
            state_q      <= RD_IDLE;
            bus.bus_req  <= 1'b0;
            bus.bus_read <= 1'b0;
            rd_busy_o    <= 1'b0;
            rd_error_o   <= 1'b1;
        end else if (stop_i) begin
            // Abort keeps the partial buffer and count for inspection.
            state_q      <= RD_IDLE;
            bus.bus_req  <= 1'b0;
            bus.bus_read <= 1'b0;
            rd_busy_o    <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (need_read_i) begin
                        if (size_legal(size_i)) begin
                            state_q         <= RD_ASK;
                            bus.bus_addr    <= addr_i;
                            bus.bus_size    <= size_i;
                            bus.bus_req     <= 1'b1;
                            word_count_rd_o <= '0;
                            rd_busy_o       <= 1'b1;
                        end else begin
                            rd_error_o <= 1'b1;
                        end
                    end
                end
                RD_ASK: begin
                    if (bus.bus_grant) begin
                        state_q      <= RD_GRANTED;
                        bus.bus_read <= 1'b1;
                    end
                end
                RD_GRANTED: begin
                    if (bus.bus_valid) begin
                        word_buf_q[wr_idx_lo] <= beat[31:0];
                        word_buf_q[wr_idx_hi] <= beat[DATA_W-1:32];
                        word_count_rd_o       <= word_count_rd_o + 8'd2;
                        if ((word_count_rd_o + 8'd2) == burst_words(bus.bus_size)) begin
                            state_q      <= RD_IDLE;
                            bus.bus_req  <= 1'b0;
                            bus.bus_read <= 1'b0;
                            rd_busy_o    <= 1'b0;
                            rd_done_o    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q          <= RD_IDLE;
                    rd_state_error_o <= 1'b1;
                    bus.bus_req      <= 1'b0;
                    bus.bus_read     <= 1'b0;
                    rd_busy_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_codma_read_machine.sv
// Directed bench for the CODMA read machine with a transaction-level model
// checked against the DUT every cycle, plus literal spot checks.
module tb_ip_codma_read_machine;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         need_read_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [3:0]   size_i = '0;
    logic         stop_i = 1'b0;
    logic [255:0] rd_buf_o;
    logic [7:0]   word_count_rd_o;
    logic         rd_done_o;
    logic         rd_error_o;
    logic         rd_state_error_o;
    logic         rd_busy_o;

    ip_codma_read_machine_if #(.DATA_W(64)) bus ();

    ip_codma_read_machine #(.BUF_WORDS(8), .DATA_W(64)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .need_read_i      (need_read_i),
        .addr_i           (addr_i),
        .size_i           (size_i),
        .stop_i           (stop_i),
        .bus              (bus),
        .rd_buf_o         (rd_buf_o),
        .word_count_rd_o  (word_count_rd_o),
        .rd_done_o        (rd_done_o),
        .rd_error_o       (rd_error_o),
        .rd_state_error_o (rd_state_error_o),
        .rd_busy_o        (rd_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    // Model: a transfer is either absent, waiting for grant, or collecting words.
    bit          m_busy, m_granted, m_done, m_err;
    int          m_count, m_target;
    logic [31:0] m_addr;
    logic [3:0]  m_size;
    logic [31:0] m_words [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs the DUT sees.
    initial begin
        forever begin
            @(posedge clk_i);
            m_done = 1'b0;
            m_err  = 1'b0;
            if (reset_i) begin
                m_busy = 0; m_granted = 0; m_count = 0; m_target = 0;
                m_addr = '0; m_size = '0;
                for (int i = 0; i < 8; i++) m_words[i] = '0;
            end else if (m_busy && bus.bus_error) begin
                m_busy = 0; m_granted = 0; m_err = 1'b1;
            end else if (stop_i) begin
                m_busy = 0; m_granted = 0;
            end else if (!m_busy) begin
                if (need_read_i) begin
                    m_target = (size_i == 4'd3) ? 2 : (size_i == 4'd8) ? 4 : (size_i == 4'd9) ? 8 : 0;
                    if (m_target == 0) begin
                        m_err = 1'b1;
                    end else begin
                        m_busy = 1; m_addr = addr_i; m_size = size_i; m_count = 0;
                    end
                end
            end else if (!m_granted) begin
                if (bus.bus_grant) m_granted = 1;
            end else if (bus.bus_valid) begin
                m_words[m_count]     = bus.bus_data[31:0];
                m_words[m_count + 1] = bus.bus_data[63:32];
                m_count += 2;
                if (m_count == m_target) begin
                    m_busy = 0; m_granted = 0; m_done = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        logic [255:0] mb;
        forever begin
            @(negedge clk_i);
            if (rd_done_o === 1'b1) n_done++;
            if (chk_en) begin
                for (int i = 0; i < 8; i++) mb[32*i +: 32] = m_words[i];
                check("bus_req",   256'(bus.bus_req),      256'(m_busy));
                check("bus_read",  256'(bus.bus_read),     256'(m_granted));
                check("bus_addr",  256'(bus.bus_addr),     256'(m_addr));
                check("bus_size",  256'(bus.bus_size),     256'(m_size));
                check("busy",      256'(rd_busy_o),        256'(m_busy));
                check("done",      256'(rd_done_o),        256'(m_done));
                check("error",     256'(rd_error_o),       256'(m_err));
                check("state_err", 256'(rd_state_error_o), 256'(0));
                check("count",     256'(word_count_rd_o),  256'(m_count));
                check("buf",       rd_buf_o,               mb);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic request(input logic [31:0] a, input logic [3:0] s);
        need_read_i = 1'b1; addr_i = a; size_i = s;
        tick(1);
        need_read_i = 1'b0; addr_i = '0; size_i = '0;
    endtask

    task automatic grant1();
        bus.bus_grant = 1'b1;
        tick(1);
        bus.bus_grant = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d);
        bus.bus_valid = 1'b1; bus.bus_data = d;
        tick(1);
        bus.bus_valid = 1'b0; bus.bus_data = '0;
    endtask

    function automatic logic [31:0] word_n(input int n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    initial begin
        int d0;
        bus.bus_grant = 1'b0; bus.bus_valid = 1'b0; bus.bus_data = '0; bus.bus_error = 1'b0;
        tick(3);
        check("reset_buf",   rd_buf_o, '0);
        check("reset_count", 256'(word_count_rd_o), 256'(0));
        reset_i = 1'b0;
        chk_en  = 1'b1;
        tick(2);

        // One-beat burst, grant after two cycles.
        request(32'h0000_1000, 4'd3);
        check("t1_req_latency", 256'(bus.bus_req), 256'(1));
        tick(2);
        grant1();
        beat(64'hAAAA_BBBB_1111_2222);
        check("t1_done",  256'(rd_done_o), 256'(1));
        check("t1_buf0",  256'(rd_buf_o[31:0]),  256'(32'h1111_2222));
        check("t1_buf1",  256'(rd_buf_o[63:32]), 256'(32'hAAAA_BBBB));
        check("t1_count", 256'(word_count_rd_o), 256'(2));
        tick(1);
        check("t1_done_off", 256'(rd_done_o), 256'(0));
        tick(1);

        // Four-beat burst with one-cycle gaps.
        d0 = n_done;
        request(32'h0000_2000, 4'd9);
        grant1();
        for (int i = 0; i < 4; i++) begin
            beat({word_n(2*i+1), word_n(2*i)});
            if (i < 3) check("t2_count_step", 256'(word_count_rd_o), 256'(2*i+2));
            if (i == 1) check("t2_addr_mid", 256'(bus.bus_addr), 256'(32'h2000));
            tick(1);
        end
        check("t2_count",   256'(word_count_rd_o), 256'(8));
        check("t2_ndone",   256'(n_done - d0), 256'(1));
        for (int n = 0; n < 8; n++) check("t2_buf", 256'(rd_buf_o[32*n +: 32]), 256'(word_n(n)));

        // Bus error on the first beat of a two-beat burst.
        d0 = n_done;
        request(32'h0000_3000, 4'd8);
        grant1();
        bus.bus_valid = 1'b1; bus.bus_data = 64'hDEAD_DEAD_DEAD_DEAD; bus.bus_error = 1'b1;
        tick(1);
        bus.bus_valid = 1'b0; bus.bus_data = '0; bus.bus_error = 1'b0;
        check("t3_error", 256'(rd_error_o), 256'(1));
        check("t3_count", 256'(word_count_rd_o), 256'(0));
        check("t3_buf0",  256'(rd_buf_o[31:0]), 256'(word_n(0)));
        tick(2);
        check("t3_ndone", 256'(n_done - d0), 256'(0));

        // Stop after two beats of a four-beat burst, then a fresh short burst.
        d0 = n_done;
        request(32'h0000_4000, 4'd9);
        grant1();
        beat(64'h2222_2222_1111_1111);
        beat(64'h4444_4444_3333_3333);
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check("t4_busy",  256'(rd_busy_o), 256'(0));
        check("t4_count", 256'(word_count_rd_o), 256'(4));
        check("t4_buf3",  256'(rd_buf_o[127:96]),  256'(32'h4444_4444));
        check("t4_buf4",  256'(rd_buf_o[159:128]), 256'(word_n(4)));
        check("t4_ndone", 256'(n_done - d0), 256'(0));
        tick(1);
        request(32'h0000_5000, 4'd3);
        check("t4_count_clr", 256'(word_count_rd_o), 256'(0));
        grant1();
        beat(64'h6666_6666_5555_5555);
        check("t4_count2", 256'(word_count_rd_o), 256'(2));
        check("t4_buf2",   256'(rd_buf_o[95:64]), 256'(32'h3333_3333));
        tick(1);

        // Illegal size, and stray beats while idle / asking / in the grant cycle.
        need_read_i = 1'b1; size_i = 4'd5; addr_i = 32'h0000_6000;
        bus.bus_valid = 1'b1; bus.bus_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick(1);
        need_read_i = 1'b0; size_i = '0; addr_i = '0;
        check("t5_error", 256'(rd_error_o), 256'(1));
        check("t5_noreq", 256'(bus.bus_req), 256'(0));
        request(32'h0000_7000, 4'd3);
        tick(1);
        bus.bus_grant = 1'b1;
        tick(1);
        bus.bus_grant = 1'b0; bus.bus_valid = 1'b0; bus.bus_data = '0;
        check("t5_count", 256'(word_count_rd_o), 256'(0));
        check("t5_buf0",  256'(rd_buf_o[31:0]), 256'(32'h5555_5555));
        beat(64'h8888_8888_7777_7777);
        check("t5_done", 256'(rd_done_o), 256'(1));
        tick(1);

        // Illegal state encoding, then reset in the middle of a burst.
        chk_en = 1'b0;
        tick(1);
        force dut.state_q = 2'b11;
        tick(1);
        release dut.state_q;
        tick(1);
        check("t6_state_err", 256'(rd_state_error_o), 256'(1));
        check("t6_idle",      256'(rd_busy_o), 256'(0));
        tick(1);
        check("t6_sticky",    256'(rd_state_error_o), 256'(1));
        request(32'h0000_8000, 4'd9);
        grant1();
        beat(64'h9999_9999_9999_9999);
        check("t6_mid_count", 256'(word_count_rd_o), 256'(2));
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        check("t6_rst_buf",   rd_buf_o, '0);
        check("t6_rst_flags", 256'({rd_state_error_o, rd_busy_o, rd_done_o, rd_error_o,
                                    bus.bus_req, bus.bus_read}), 256'(0));
        check("t6_rst_count", 256'(word_count_rd_o), 256'(0));
        check("t6_rst_addr",  256'(bus.bus_addr), 256'(0));
        chk_en = 1'b1;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
